// File: rtl/osd_dii_type_demux_pkg.sv
// Shared DII definitions: flit type, packet TYPE codes and the demux FSM states.
package osd_dii_type_demux_pkg;

  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;

  localparam logic [1:0] DII_TYPE_REG   = 2'b00;
  localparam logic [1:0] DII_TYPE_PLAIN = 2'b01;
  localparam logic [1:0] DII_TYPE_EVENT = 2'b10;

  localparam int unsigned FLAGS_TYPE_MSB = 15;
  localparam int unsigned FLAGS_TYPE_LSB = 14;

  typedef enum logic [2:0] {
    HDR0,
    HDR1,
    HDR2,
    REPLAY,
    PASS,
    DROP
  } demux_state_t;

  function automatic logic is_reg_type(input logic [15:0] flags);
    return flags[FLAGS_TYPE_MSB:FLAGS_TYPE_LSB] == DII_TYPE_REG;
  endfunction

endpackage

// File: rtl/osd_dii_type_demux_if.sv
// One DII flit channel: flit bundle travels master->slave, ready travels back.
interface osd_dii_type_demux_if
  import osd_dii_type_demux_pkg::*;
  ();

  dii_flit flit;
  logic    ready;

  modport master (output flit, input ready);
  modport slave  (input flit, output ready);

endinterface

// File: rtl/osd_dii_type_demux_hdr_buf.sv
// Three-entry header store (DEST, SRC, FLAGS) with a replay read index.
module osd_dii_hdr_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [1:0]  wr_idx,
  input  logic [15:0] wr_data,
  input  logic        rd_clr,
  input  logic        rd_adv,
  output logic [15:0] rd_data,
  output logic        rd_at_end
);

  logic [15:0] hdr [3];
  logic [1:0]  rd_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 3; i++) hdr[i] <= '0;
      rd_idx <= '0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (wr_en && (wr_idx == 2'(i))) hdr[i] <= wr_data;
      end
      // The index parks on the FLAGS entry; the next header restarts it.
      if (rd_clr) rd_idx <= '0;
      else if (rd_adv && !rd_at_end) rd_idx <= rd_idx + 2'd1;
    end
  end

  always_comb begin
    rd_data = '0;
    case (rd_idx)
      2'd0:    rd_data = hdr[0];
      2'd1:    rd_data = hdr[1];
      2'd2:    rd_data = hdr[2];
      default: rd_data = '0;
    endcase
  end

  assign rd_at_end = (rd_idx == 2'd2);

endmodule

// File: rtl/osd_dii_type_demux.sv
// Buffers the DII header, classifies by FLAGS TYPE and forwards the packet
// unchanged to the register-access or bypass output (or drops it).
module osd_dii_type_demux
  import osd_dii_type_demux_pkg::*;
#(
  parameter bit          DROP_NON_REG = 1'b0,
  parameter int unsigned CNT_WIDTH    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  osd_dii_type_demux_if.slave  debug_in,
  osd_dii_type_demux_if.master reg_out,
  osd_dii_type_demux_if.master bypass_out,
  output logic [CNT_WIDTH-1:0] drop_cnt
);

  demux_state_t state, state_nx;

  logic        sel_reg;
  logic        hdr_last;
  logic        in_ready;
  logic        accept;
  logic        out_ready;
  logic        drop_inc;
  logic        hdr_latch;
  logic        hb_wr;
  logic [1:0]  hb_wr_idx;
  logic        hb_rd_clr;
  logic        hb_rd_adv;
  logic [15:0] hb_rd_data;
  logic        hb_rd_at_end;
  dii_flit     sel_flit;

  osd_dii_hdr_buf u_hdr_buf (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (hb_wr),
    .wr_idx    (hb_wr_idx),
    .wr_data   (debug_in.flit.data),
    .rd_clr    (hb_rd_clr),
    .rd_adv    (hb_rd_adv),
    .rd_data   (hb_rd_data),
    .rd_at_end (hb_rd_at_end)
  );

  assign accept    = debug_in.flit.valid & debug_in.ready;
  assign out_ready = sel_reg ? reg_out.ready : bypass_out.ready;

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    sel_flit  = '0;
    hb_wr     = 1'b0;
    hb_wr_idx = 2'd0;
    hb_rd_clr = 1'b0;
    hb_rd_adv = 1'b0;
    drop_inc  = 1'b0;
    hdr_latch = 1'b0;

    case (state)
      HDR0, HDR1: begin
        in_ready  = 1'b1;
        hb_wr_idx = (state == HDR0) ? 2'd0 : 2'd1;
        if (accept) begin
          hb_wr = 1'b1;
          if (debug_in.flit.last) begin
            drop_inc = 1'b1;
            state_nx = HDR0;
          end else begin
            state_nx = (state == HDR0) ? HDR1 : HDR2;
          end
        end
      end

      HDR2: begin
        in_ready  = 1'b1;
        hb_wr_idx = 2'd2;
        if (accept) begin
          hb_wr     = 1'b1;
          hb_rd_clr = 1'b1;
          hdr_latch = 1'b1;
          if (!is_reg_type(debug_in.flit.data) && DROP_NON_REG) begin
            drop_inc = 1'b1;
            state_nx = debug_in.flit.last ? HDR0 : DROP;
          end else begin
            state_nx = REPLAY;
          end
        end
      end

      REPLAY: begin
        sel_flit.valid = 1'b1;
        sel_flit.last  = hb_rd_at_end & hdr_last;
        sel_flit.data  = hb_rd_data;
        if (out_ready) begin
          hb_rd_adv = 1'b1;
          if (hb_rd_at_end) state_nx = hdr_last ? HDR0 : PASS;
        end
      end

      PASS: begin
        sel_flit = debug_in.flit;
        in_ready = out_ready;
        if (debug_in.flit.valid && out_ready && debug_in.flit.last) state_nx = HDR0;
      end

      DROP: begin
        in_ready = 1'b1;
        if (accept && debug_in.flit.last) state_nx = HDR0;
      end

      default: state_nx = HDR0;
    endcase
  end

  // Ready is forced low while rst is high so nothing looks accepted that cycle.
  assign debug_in.ready   = in_ready & ~rst;
  assign reg_out.flit     = sel_reg ? sel_flit : '0;
  assign bypass_out.flit  = sel_reg ? '0 : sel_flit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HDR0;
      sel_reg  <= 1'b0;
      hdr_last <= 1'b0;
      drop_cnt <= '0;
    end else begin
      state <= state_nx;
      if (hdr_latch) begin
        sel_reg  <= is_reg_type(debug_in.flit.data);
        hdr_last <= debug_in.flit.last;
      end
      if (drop_inc && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_osd_dii_type_demux.sv
// Scoreboard bench for osd_dii_type_demux: dut0 routes, dut1 drops non-REG with a 2-bit counter.
module tb_osd_dii_type_demux;
  import osd_dii_type_demux_pkg::*;

  typedef struct packed {
    logic        last;
    logic [15:0] data;
  } fl_t;

  typedef struct packed {
    logic            which;
    logic [3:0]      n;
    logic [1:0]      route;  // 0 reg, 1 bypass, 2 dropped
    logic [7:0]      drop;
    logic [7:0][15:0] d;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] drop_cnt0;
  logic [1:0] drop_cnt1;

  osd_dii_type_demux_if in0 ();
  osd_dii_type_demux_if r0 ();
  osd_dii_type_demux_if b0 ();
  osd_dii_type_demux_if in1 ();
  osd_dii_type_demux_if r1 ();
  osd_dii_type_demux_if b1 ();

  osd_dii_type_demux dut0 (
    .clk(clk), .rst(rst), .debug_in(in0.slave), .reg_out(r0.master),
    .bypass_out(b0.master), .drop_cnt(drop_cnt0)
  );

  osd_dii_type_demux #(.DROP_NON_REG(1'b1), .CNT_WIDTH(2)) dut1 (
    .clk(clk), .rst(rst), .debug_in(in1.slave), .reg_out(r1.master),
    .bypass_out(b1.master), .drop_cnt(drop_cnt1)
  );

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned cyc = 0;
  int unsigned pc = 0;
  logic [3:0]  pat0 = 4'b1111;

  fl_t     src [2][$];
  fl_t     expq [4][$];
  vec_t    vecs [$];
  bit      hs_in [2];
  bit      stall_v [4];
  dii_flit stall_f [4];

  int unsigned in_idx0 = 0, out_idx0 = 0, pend0 = 0;
  int unsigned flags0 = 0, first_hs0 = 0, third_hs0 = 0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic mon(input int k, input dii_flit f, input logic rdy);
    fl_t e;
    if (stall_v[k])
      chk(f.valid && f.last == stall_f[k].last && f.data == stall_f[k].data,
          $sformatf("hold_out%0d", k), 32'(f), 32'({1'b1, stall_f[k].last, stall_f[k].data}));
    stall_v[k] = f.valid && !rdy;
    stall_f[k] = f;
    if (f.valid && expq[k].size() == 0) begin
      chk(1'b0, $sformatf("unexpected_valid_out%0d", k), 32'(f), 32'h0);
    end else if (f.valid && rdy) begin
      e = expq[k].pop_front();
      chk(f.last == e.last && f.data == e.data, $sformatf("flit_out%0d", k),
          32'({f.last, f.data}), 32'({e.last, e.data}));
    end
  endtask

  always @(negedge clk) begin
    logic ohs, olast;
    cyc++;
    if (rst) begin
      hs_in[0] = 1'b0;
      hs_in[1] = 1'b0;
      for (int i = 0; i < 4; i++) stall_v[i] = 1'b0;
    end else begin
      if (pend0 > 0) chk(!in0.ready, "in_ready_in_replay", 32'(in0.ready), 32'h0);
      mon(0, r0.flit, r0.ready);
      mon(1, b0.flit, b0.ready);
      mon(2, r1.flit, r1.ready);
      mon(3, b1.flit, b1.ready);
      hs_in[0] = in0.flit.valid && in0.ready;
      hs_in[1] = in1.flit.valid && in1.ready;
      ohs   = (r0.flit.valid && r0.ready) || (b0.flit.valid && b0.ready);
      olast = r0.flit.valid ? r0.flit.last : b0.flit.last;
      if (ohs) begin
        if (out_idx0 == 0) first_hs0 = cyc;
        if (out_idx0 == 2) third_hs0 = cyc;
        if (pend0 > 0) pend0--;
        out_idx0 = olast ? 0 : out_idx0 + 1;
      end
      if (hs_in[0]) begin
        if (in_idx0 == 2) begin
          flags0 = cyc;
          pend0  = 3;
        end
        in_idx0 = in0.flit.last ? 0 : in_idx0 + 1;
      end
    end
  end

  task automatic drive_src(input int w);
    dii_flit f;
    f = '0;
    if (hs_in[w] && src[w].size() > 0) void'(src[w].pop_front());
    if (src[w].size() > 0) begin
      f.valid = 1'b1;
      f.last  = src[w][0].last;
      f.data  = src[w][0].data;
    end
    if (w == 0) in0.flit = f;
    else        in1.flit = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drive_src(0);
    drive_src(1);
    pc++;
    r0.ready = pat0[2'(pc % 4)];
  endtask

  task automatic send(input vec_t v);
    fl_t f;
    for (int i = 0; i < int'(v.n); i++) begin
      f.last = (i == int'(v.n) - 1);
      f.data = v.d[i];
      src[v.which].push_back(f);
      if (v.route != 2'd2) expq[2 * v.which + v.route].push_back(f);
    end
  endtask

  task automatic wait_idle(input int w);
    int unsigned b = 0;
    while ((src[w].size() > 0 || expq[2*w].size() > 0 || expq[2*w+1].size() > 0) && b < 300) begin
      tick();
      b++;
    end
    chk(b < 300, "idle_timeout", b, 300);
    tick();
    tick();
  endtask

  task automatic addv(input logic w, input int n, input int route, input int drop,
                      input logic [15:0] f0 = 0, input logic [15:0] f1 = 0,
                      input logic [15:0] f2 = 0, input logic [15:0] f3 = 0,
                      input logic [15:0] f4 = 0, input logic [15:0] f5 = 0);
    vec_t v;
    v       = '0;
    v.which = w;
    v.n     = 4'(n);
    v.route = 2'(route);
    v.drop  = 8'(drop);
    v.d[0] = f0; v.d[1] = f1; v.d[2] = f2; v.d[3] = f3; v.d[4] = f4; v.d[5] = f5;
    vecs.push_back(v);
  endtask

  initial begin
    vec_t v;
    int unsigned b;

    in0.flit = '0; in1.flit = '0;
    r0.ready = 1'b1; b0.ready = 1'b1; r1.ready = 1'b1; b1.ready = 1'b1;

    tick();
    chk(!in0.ready, "rst_in_ready0", 32'(in0.ready), 32'h0);
    chk(!in1.ready, "rst_in_ready1", 32'(in1.ready), 32'h0);
    tick();
    rst = 1'b0;
    chk(r0.flit == '0 && b0.flit == '0, "rst_out0", 32'({r0.flit.valid, b0.flit.valid}), 32'h0);
    chk(r1.flit == '0 && b1.flit == '0, "rst_out1", 32'({r1.flit.valid, b1.flit.valid}), 32'h0);
    chk(drop_cnt0 == 8'd0, "rst_drop0", 32'(drop_cnt0), 32'h0);
    chk(drop_cnt1 == 2'd0, "rst_drop1", 32'(drop_cnt1), 32'h0);
    tick();

    // REG read, checking presentation latency and back-to-back replay length
    addv(0, 4, 0, 0, 16'h0005, 16'h0001, 16'h2000, 16'h0003);
    send(vecs.pop_back());
    wait_idle(0);
    chk(first_hs0 - flags0 == 1, "replay_latency", first_hs0 - flags0, 1);
    chk(third_hs0 - first_hs0 == 2, "replay_length", third_hs0 - first_hs0, 2);

    addv(0, 5, 1, 0, 16'h0000, 16'h0005, 16'h8000, 16'h1234, 16'hABCD);
    addv(0, 1, 2, 1, 16'h0005);
    addv(0, 4, 0, 1, 16'h0005, 16'h0001, 16'h2000, 16'h0003);
    addv(0, 2, 2, 2, 16'h0003, 16'h0004);
    addv(0, 3, 1, 2, 16'h0001, 16'h0002, 16'h4000);
    addv(0, 3, 0, 2, 16'h0007, 16'h0008, 16'h3FFF);
    addv(0, 6, 1, 2, 16'h0001, 16'h0002, 16'hC000, 16'h5555, 16'h6666, 16'h7777);
    addv(1, 6, 2, 1, 16'h0001, 16'h0002, 16'h4000, 16'h0001, 16'h0002, 16'h0003);
    addv(1, 4, 0, 1, 16'h0005, 16'h0001, 16'h2000, 16'h0003);
    addv(1, 3, 2, 2, 16'h0000, 16'h0005, 16'h8000);
    addv(1, 1, 2, 3, 16'h0009);
    addv(1, 4, 2, 3, 16'h0000, 16'h0005, 16'h8000, 16'h1111);
    addv(1, 5, 2, 3, 16'h0001, 16'h0002, 16'h4000, 16'h2222, 16'h3333);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      send(v);
      wait_idle(int'(v.which));
      if (v.which == 1'b0) chk(drop_cnt0 == v.drop, $sformatf("drop_cnt0_v%0d", i), 32'(drop_cnt0), 32'(v.drop));
      else                 chk(drop_cnt1 == v.drop[1:0], $sformatf("drop_cnt1_v%0d", i), 32'(drop_cnt1), 32'(v.drop[1:0]));
    end

    // reg_out ready toggling 1,0,0,1 across replay and pass-through
    pat0 = 4'b1001;
    addv(0, 6, 0, 2, 16'h0005, 16'h0001, 16'h2000, 16'h00A1, 16'h00A2, 16'h00A3);
    send(vecs.pop_back());
    wait_idle(0);
    pat0 = 4'b1111;
    tick();

    // reset while replay sits at idx 1
    addv(0, 6, 0, 0, 16'h0F01, 16'h0F02, 16'h0003, 16'h0F04, 16'h0F05, 16'h0F06);
    send(vecs.pop_back());
    b = 0;
    while (out_idx0 != 1 && b < 100) begin
      tick();
      b++;
    end
    chk(out_idx0 == 1, "reach_replay_idx1", out_idx0, 1);
    pat0 = 4'b0000;
    r0.ready = 1'b0;
    rst = 1'b1;
    #1;
    chk(!in0.ready, "midrst_in_ready", 32'(in0.ready), 32'h0);
    src[0].delete(); src[1].delete();
    for (int k = 0; k < 4; k++) expq[k].delete();
    in_idx0 = 0; out_idx0 = 0; pend0 = 0;
    tick();
    rst = 1'b0;
    chk(!r0.flit.valid && !b0.flit.valid, "midrst_out_valid", 32'({r0.flit.valid, b0.flit.valid}), 32'h0);
    chk(drop_cnt0 == 8'd0, "midrst_drop0", 32'(drop_cnt0), 32'h0);
    chk(drop_cnt1 == 2'd0, "midrst_drop1", 32'(drop_cnt1), 32'h0);
    pat0 = 4'b1111;
    addv(0, 4, 0, 0, 16'h0011, 16'h0022, 16'h0033, 16'h0044);
    send(vecs.pop_back());
    wait_idle(0);
    chk(drop_cnt0 == 8'd0, "post_rst_drop0", 32'(drop_cnt0), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/osd_dii_type_demux.md
Name: osd_dii_type_demux

Overview:
- Sits directly upstream of the register-access stage in every OSD debug module.
- Accepts the DII packet stream from the debug ring.
- Buffers the three header flits (DEST, SRC, FLAGS), classifies the packet by TYPE = FLAGS[15:14], then replays and forwards the whole packet unchanged:
  - TYPE == 2'b00 (REG) goes to the register-access output.
  - Any other TYPE goes to the module-specific bypass output.

Parameters:
- DROP_NON_REG, 0: when 1, non-REG packets are consumed and discarded instead of routed to bypass.
- CNT_WIDTH, 8: width of the saturating dropped-packet counter.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- debug_in  input  dii_flit  incoming packet stream (valid, last, data[15:0])
- debug_in_ready  output  1  flit accepted when debug_in.valid & debug_in_ready
- reg_out  output  dii_flit  REG packets toward the register-access stage
- reg_out_ready  input  1  downstream ready
- bypass_out  output  dii_flit  non-REG packets
- bypass_out_ready  input  1  downstream ready
- drop_cnt  output  CNT_WIDTH  saturating count of dropped packets

Behaviour:
- Interface (decided): single clock clk; reset rst is synchronous and active-high.
- Reset:
  - state=HDR0; reg_out and bypass_out all-zero (valid=0, last=0); debug_in_ready=0 during the rst cycle; drop_cnt=0.
  - Header buffer and route flag are cleared.
  - Reset mid-packet discards all buffered flits; no partial packet is emitted afterwards.
- Handshake: valid/ready per flit. An output's valid never depends on its own ready. Outputs hold data stable while valid & !ready.
- States: HDR0, HDR1, HDR2, REPLAY, PASS, DROP.
- HDR0/HDR1/HDR2:
  - debug_in_ready=1; on each accepted flit, store data into hdr[0..2].
  - Accepted flit with last in HDR0 or HDR1: malformed short packet. Drop it, drop_cnt+1 (saturating), go to HDR0. Nothing is emitted.
  - On accept in HDR2:
    - Latch sel_reg = (data[15:14]==2'b00) and hdr_last = last, and set idx=0.
    - If !sel_reg & DROP_NON_REG:
      - With last: drop_cnt+1, go to HDR0.
      - Otherwise: go to DROP (drop_cnt+1 at entry).
    - Else go to REPLAY.
- REPLAY:
  - debug_in_ready=0.
  - Selected output: valid=1, data=hdr[idx], last = (idx==2) & hdr_last. Unselected output stays all-zero.
  - idx increments on handshake. Handshake at idx==2 goes to HDR0 if hdr_last, else PASS.
  - Latency: first replay flit is presented the cycle after the FLAGS flit is accepted. A back-to-back 3-flit replay with ready held high takes 3 cycles.
- PASS:
  - Combinational pass-through: selected output = debug_in, and debug_in_ready = selected output's ready. The unselected output's ready is ignored.
  - Handshake with last goes to HDR0.
- DROP: debug_in_ready=1; accepted flit with last goes to HDR0.
- Inter-packet gap: at most 1 cycle, the HDR0 acceptance following the last flit. No flit of packet N+1 is accepted before packet N's last flit handshakes.
- Simultaneous events:
  - Both ready inputs high: only the selected one matters.
  - drop_cnt at all-ones stays all-ones.
- Data is never modified; flit order is preserved exactly.

Decomposition:
- dii_package (existing): dii_flit typedef.
- New constants added to the shared package: DII_TYPE_REG=2'b00, DII_TYPE_PLAIN=2'b01, DII_TYPE_EVENT=2'b10, and FLAGS_TYPE_MSB/LSB=15/14. The regaccess stage also uses these.
- Sub-module: osd_dii_hdr_buf, a 3-entry header store with write and replay index logic.
- The FSM and muxing stay in the top module.

Test Plan:
- 4-flit REG read {0x0005,0x0001,0x2000,0x0003}, both readys high:
  - identical 4 flits on reg_out, last on the 4th;
  - bypass_out.valid stays 0;
  - first reg_out valid 1 cycle after FLAGS accept.
- Event packet {0x0000,0x0005,0x8000,0x1234,0xABCD}: routed to bypass_out unchanged, last on 0xABCD; reg_out idle.
- Backpressure: REG packet with reg_out_ready toggling 1,0,0,1 per cycle:
  - no flit lost or duplicated;
  - data stable while stalled;
  - debug_in_ready=0 throughout REPLAY.
- Short packet {0x0005(last)} then a valid REG packet: drop_cnt=1, nothing emitted for the short packet, and the following packet is forwarded intact.
- DROP_NON_REG=1: PLAIN packet with FLAGS 0x4000 and 6 flits is fully consumed with no output activity and drop_cnt increments by 1. CNT_WIDTH=2 with 5 drops gives drop_cnt=3.
- rst asserted during REPLAY idx=1:
  - next cycle both outputs valid=0, drop_cnt=0;
  - a new REG packet is forwarded correctly with no stale header flits.
